sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: SRAM clock cycles per halfword phase; legal range 1..7.
REQ-002 SHALL have parameter MEM_BASE, default 32'd1024: first data-memory byte address.
REQ-003 SHALL have parameter SRAM_ADDR_LEN, default 18: width of the SRAM halfword address.
REQ-004 Clock and reset are fixed: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 wr_en  in  1  write request from MEM stage, held until ready.
REQ-008 rd_en  in  1  read request from MEM stage, held until ready.
REQ-009 address  in  32  byte address from the ALU result.
REQ-010 write_data  in  32  store data (Rm value).
REQ-011 read_data  out  32  load data, valid while ready=1 after a read.
REQ-012 ready  out  1  high when no request is pending or an access has completed; pipeline freeze = ~ready.
REQ-013 sram_addr  out  SRAM_ADDR_LEN  SRAM halfword address.
REQ-014 sram_dq_out  out  16  halfword driven to SRAM.
REQ-015 sram_dq_in  in  16  halfword returned by SRAM.
REQ-016 sram_dq_oe  out  1  SRAM data bus output enable.
REQ-017 sram_we_n  out  1  SRAM write strobe, active low.
REQ-018 addr_err  out  1  one-cycle out-of-range flag; present only under SRAM_ADDR_CHECK_EN.

Function
REQ-019 States SHALL be IDLE, LO, HI and DONE; a wait counter of 3 bits SHALL time each of LO and HI.
REQ-020 In IDLE, if wr_en or rd_en is high, the block SHALL capture address, write_data and the operation, then go to LO.
REQ-021 If wr_en and rd_en are both high, the operation SHALL be a write.
REQ-022 The word offset SHALL be (address - MEM_BASE) >> 2, truncated to SRAM_ADDR_LEN-1 bits.
REQ-023 sram_addr SHALL be {offset,1'b0} in LO and {offset,1'b1} in HI.
REQ-024 LO and HI SHALL each last exactly WAIT_CYCLES cycles, then advance: LO->HI->DONE.
REQ-025 DONE SHALL last exactly one cycle and then always return to IDLE.
REQ-026 Write: in LO and HI, sram_dq_oe=1 and sram_we_n=0; sram_dq_out SHALL be write_data[15:0] in LO and write_data[31:16] in HI.
REQ-027 Read: sram_dq_oe=1'b0 and sram_we_n=1; sram_dq_in SHALL be sampled in the last cycle of LO into read_data[15:0], and in the last cycle of HI into read_data[31:16].
REQ-028 ready SHALL be combinational: 1 in DONE; 1 in IDLE with no request; 0 otherwise.
REQ-029 Latency: a request first seen in IDLE at cycle 0 SHALL see ready=1 at cycle 1+2*WAIT_CYCLES.
REQ-030 After capture, inputs SHALL be ignored until IDLE; a request dropped mid-access SHALL still complete.
REQ-031 A request still held in the DONE cycle SHALL NOT restart; a request held in the next IDLE cycle SHALL start a new access.
REQ-032 read_data SHALL hold its value until the next read overwrites it; writes SHALL NOT change it.
REQ-033 Outside LO/HI: sram_we_n=1, sram_dq_oe=0, sram_dq_out=0, sram_addr=0.

Reset
REQ-034 rst SHALL force IDLE, counter=0, read_data=0, captured registers=0, sram_we_n=1, sram_dq_oe=0, and addr_err=0, at any time.
REQ-035 Reset during LO/HI SHALL abort the access at once; no further strobe SHALL be issued; ready SHALL follow REQ-028 from IDLE.

Configuration
REQ-036 With SRAM_ADDR_CHECK_EN defined: a request with address < MEM_BASE, or with offset >= 2^(SRAM_ADDR_LEN-1), SHALL go IDLE->DONE with no strobe, pulse addr_err for the DONE cycle, and leave read_data unchanged.
REQ-037 Without SRAM_ADDR_CHECK_EN: addr_err SHALL be absent, and out-of-range addresses SHALL wrap per REQ-022.

Verification
REQ-038 WAIT_CYCLES=2; write 0xDEADBEEF to 1028 -> sram_addr=2 with dq 0xBEEF for 2 cycles, then 3 with 0xDEAD for 2 cycles; ready=1 at cycle 5.
REQ-039 Read 1028 with the SRAM model returning 0xBEEF then 0xDEAD -> read_data=0xDEADBEEF and ready=1 at cycle 5; sram_we_n stays 1 throughout.
REQ-040 rd_en and wr_en both high at 1024 -> write performed; read_data unchanged.
REQ-041 Assert rst in the second LO cycle of a write -> sram_we_n=1 at once, state IDLE, no HI phase.
REQ-042 Back-to-back: read held through DONE and one IDLE cycle -> second access begins from IDLE, ready=0 in that cycle.
REQ-043 With SRAM_ADDR_CHECK_EN defined, read at 1020 -> ready=1 and addr_err=1 at cycle 1, with no strobe.

Source files
------------

// File: rtl/sram_controller.sv
// sram_controller: 32-bit word access over a 16-bit asynchronous SRAM.
// Each access is split into a low-halfword phase (LO) and a high-halfword
// phase (HI). Each phase lasts WAIT_CYCLES clocks, and a one-cycle DONE
// handshake follows.
// Optional build macro SRAM_ADDR_CHECK_EN adds range checking and the
// addr_err flag. Out-of-range requests then skip straight to DONE.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES   = 2,
  parameter logic [31:0] MEM_BASE      = 32'd1024,
  parameter int unsigned SRAM_ADDR_LEN = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [31:0]              address,
  input  logic [31:0]              write_data,
  output logic [31:0]              read_data,
  output logic                     ready,
  output logic [SRAM_ADDR_LEN-1:0] sram_addr,
  output logic [15:0]              sram_dq_out,
  input  logic [15:0]              sram_dq_in,
  output logic                     sram_dq_oe,
  output logic                     sram_we_n
`ifdef SRAM_ADDR_CHECK_EN
  ,
  output logic                     addr_err
`endif
);

  localparam int unsigned OFF_W = SRAM_ADDR_LEN - 1;
  localparam logic [2:0]  LAST  = 3'(WAIT_CYCLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [2:0]       cnt;
  logic [OFF_W-1:0] off_q;
  logic [31:0]      wdata_q;
  logic             wr_q;
  logic [31:0]      diff;
  logic             req;

  assign diff = address - MEM_BASE;
  assign req  = wr_en | rd_en;

`ifdef SRAM_ADDR_CHECK_EN
  logic bad_addr;
  // Below the base, or past the last halfword pair the SRAM can hold.
  assign bad_addr = (address < MEM_BASE) || (diff[31:SRAM_ADDR_LEN+1] != '0);
  logic unused_bits;
  assign unused_bits = &{1'b0, diff[1:0]};
`else
  logic unused_bits;
  assign unused_bits = &{1'b0, diff[1:0], diff[31:SRAM_ADDR_LEN+1]};
`endif

  // Access sequencer: capture in IDLE, time LO/HI, and sample read halves on
  // the last cycle of each phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      off_q     <= '0;
      wdata_q   <= 32'd0;
      wr_q      <= 1'b0;
      read_data <= 32'd0;
`ifdef SRAM_ADDR_CHECK_EN
      addr_err  <= 1'b0;
`endif
    end else begin
`ifdef SRAM_ADDR_CHECK_EN
      addr_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= 3'd0;
          if (req) begin
`ifdef SRAM_ADDR_CHECK_EN
            if (bad_addr) begin
              state    <= DONE;
              addr_err <= 1'b1;
            end else begin
              off_q   <= diff[SRAM_ADDR_LEN:2];
              wdata_q <= write_data;
              wr_q    <= wr_en;
              state   <= LO;
            end
`else
            off_q   <= diff[SRAM_ADDR_LEN:2];
            wdata_q <= write_data;
            wr_q    <= wr_en;   // write wins when both are requested
            state   <= LO;
`endif
          end
        end
        LO: begin
          if (cnt == LAST) begin
            cnt   <= 3'd0;
            state <= HI;
            if (!wr_q) read_data[15:0] <= sram_dq_in;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        HI: begin
          if (cnt == LAST) begin
            cnt   <= 3'd0;
            state <= DONE;
            if (!wr_q) read_data[31:16] <= sram_dq_in;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: state <= IDLE;   // DONE never restarts, even with a held request
      endcase
    end
  end

  // SRAM pins are decoded from state, so a reset drops the strobe immediately.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    if (state == LO || state == HI) begin
      sram_addr = {off_q, state == HI};
      if (wr_q) begin
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
        sram_dq_out = (state == HI) ? wdata_q[31:16] : wdata_q[15:0];
      end
    end
  end

  // Pipeline freeze is ~ready, so a new request drops ready in the same cycle.
  always_comb begin
    ready = (state == DONE) || (state == IDLE && !req);
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with WAIT_CYCLES=2 and a tiny SRAM model.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;
`ifdef SRAM_ADDR_CHECK_EN
  logic        addr_err;
`endif

  logic [15:0] mem_lo, mem_hi;
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  // The SRAM model returns mem_hi on odd halfword addresses and mem_lo on even ones.
  assign sram_dq_in = sram_addr[0] ? mem_hi : mem_lo;

  sram_controller #(.WAIT_CYCLES(2), .MEM_BASE(32'd1024), .SRAM_ADDR_LEN(18)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
`ifdef SRAM_ADDR_CHECK_EN
    , .addr_err(addr_err)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    address = 32'd0; write_data = 32'd0;
    mem_lo = 16'h0000; mem_hi = 16'h0000;
    #1;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_we_n", 32'(sram_we_n), 1);
    chk("rst_oe", 32'(sram_dq_oe), 0);
    chk("rst_rdata", read_data, 0);
    chk("rst_addr", 32'(sram_addr), 0);
    tick; tick;
    rst = 1'b0;
    tick;

    // Write 0xDEADBEEF to 1028 (offset 1 -> halfwords 2, 3).
    address = 32'd1028; write_data = 32'hDEADBEEF; wr_en = 1'b1;
    #1 chk("wr_c0_ready", 32'(ready), 0);
    for (int c = 1; c <= 4; c++) begin
      tick;
      chk($sformatf("wr_c%0d_addr", c), 32'(sram_addr), (c <= 2) ? 2 : 3);
      chk($sformatf("wr_c%0d_dq", c), 32'(sram_dq_out), (c <= 2) ? 32'hBEEF : 32'hDEAD);
      chk($sformatf("wr_c%0d_we_n", c), 32'(sram_we_n), 0);
      chk($sformatf("wr_c%0d_oe", c), 32'(sram_dq_oe), 1);
      chk($sformatf("wr_c%0d_ready", c), 32'(ready), 0);
    end
    tick;
    chk("wr_c5_ready", 32'(ready), 1);
    chk("wr_c5_we_n", 32'(sram_we_n), 1);
    chk("wr_c5_addr", 32'(sram_addr), 0);
    wr_en = 1'b0;
    tick;
    chk("wr_idle_ready", 32'(ready), 1);

    // Read 1028, SRAM returns 0xBEEF then 0xDEAD.
    mem_lo = 16'hBEEF; mem_hi = 16'hDEAD;
    address = 32'd1028; rd_en = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick;
      chk($sformatf("rd_c%0d_we_n", c), 32'(sram_we_n), 1);
      chk($sformatf("rd_c%0d_oe", c), 32'(sram_dq_oe), 0);
      chk($sformatf("rd_c%0d_ready", c), 32'(ready), 0);
    end
    tick;
    chk("rd_c5_ready", 32'(ready), 1);
    chk("rd_c5_data", read_data, 32'hDEADBEEF);
    rd_en = 1'b0;
    tick;

    // Both requests at 1024: the write wins and read_data stays.
    address = 32'd1024; write_data = 32'h12345678; wr_en = 1'b1; rd_en = 1'b1;
    tick;
    chk("both_c1_addr", 32'(sram_addr), 0);
    chk("both_c1_we_n", 32'(sram_we_n), 0);
    chk("both_c1_dq", 32'(sram_dq_out), 32'h5678);
    tick; tick;
    chk("both_c3_addr", 32'(sram_addr), 1);
    chk("both_c3_dq", 32'(sram_dq_out), 32'h1234);
    tick; tick;
    chk("both_c5_ready", 32'(ready), 1);
    chk("both_rdata", read_data, 32'hDEADBEEF);
    wr_en = 1'b0; rd_en = 1'b0;
    tick;

    // Reset in the second LO cycle of a write aborts the write immediately.
    address = 32'd1028; write_data = 32'hCAFEF00D; wr_en = 1'b1;
    tick; tick;
    chk("rstmid_pre_we_n", 32'(sram_we_n), 0);
    rst = 1'b1; wr_en = 1'b0;
    #1;
    chk("rstmid_we_n", 32'(sram_we_n), 1);
    chk("rstmid_oe", 32'(sram_dq_oe), 0);
    chk("rstmid_addr", 32'(sram_addr), 0);
    chk("rstmid_ready", 32'(ready), 1);
    chk("rstmid_rdata", read_data, 0);
    tick;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick;
      chk($sformatf("rstmid_post%0d_we_n", c), 32'(sram_we_n), 1);
      chk($sformatf("rstmid_post%0d_addr", c), 32'(sram_addr), 0);
    end

    // Back-to-back reads with the request held through DONE.
    mem_lo = 16'h1357; mem_hi = 16'h2468;
    address = 32'd1028; rd_en = 1'b1;
    tick; tick; tick; tick; tick;
    chk("b2b_c5_ready", 32'(ready), 1);
    chk("b2b_c5_data", read_data, 32'h24681357);
    tick;
    chk("b2b_c6_ready", 32'(ready), 0);
    chk("b2b_c6_addr", 32'(sram_addr), 0);
    mem_lo = 16'hAAAA; mem_hi = 16'h5555;
    tick;
    chk("b2b_c7_addr", 32'(sram_addr), 2);
    chk("b2b_c7_ready", 32'(ready), 0);
    tick; tick;
    chk("b2b_c9_addr", 32'(sram_addr), 3);
    tick; tick;
    chk("b2b_c11_ready", 32'(ready), 1);
    chk("b2b_c11_data", read_data, 32'h5555AAAA);
    rd_en = 1'b0;
    tick;

    // A write request dropped after capture still completes.
    address = 32'd1032; write_data = 32'h0BADCAFE; wr_en = 1'b1;
    tick;
    chk("drop_c1_addr", 32'(sram_addr), 4);
    wr_en = 1'b0;
    #1 chk("drop_c1_ready", 32'(ready), 0);
    tick; tick;
    chk("drop_c3_addr", 32'(sram_addr), 5);
    chk("drop_c3_dq", 32'(sram_dq_out), 32'h0BAD);
    chk("drop_c3_we_n", 32'(sram_we_n), 0);
    tick; tick;
    chk("drop_c5_ready", 32'(ready), 1);
    tick;

`ifdef SRAM_ADDR_CHECK_EN
    // A read below the base is rejected with addr_err and no strobe.
    address = 32'd1020; rd_en = 1'b1;
    tick;
    chk("err_c1_ready", 32'(ready), 1);
    chk("err_c1_flag", 32'(addr_err), 1);
    chk("err_c1_we_n", 32'(sram_we_n), 1);
    chk("err_c1_addr", 32'(sram_addr), 0);
    chk("err_rdata", read_data, 32'h5555AAAA);
    rd_en = 1'b0;
    tick;
    chk("err_c2_flag", 32'(addr_err), 0);
`else
    // Without the check, 1020 wraps to offset 0x1FFFF.
    address = 32'd1020; write_data = 32'h0; wr_en = 1'b1;
    tick;
    chk("wrap_c1_addr", 32'(sram_addr), 32'h3FFFE);
    wr_en = 1'b0;
    tick; tick;
    chk("wrap_c3_addr", 32'(sram_addr), 32'h3FFFF);
    tick; tick;
    chk("wrap_c5_ready", 32'(ready), 1);
`endif
    tick;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
